// File: rtl/adc_conv_sequencer.sv
// Conversion sequencer and FWFT result buffer placed in front of adc_top.
// Issues single-shot or periodic start pulses, resynchronises the ADC's
// asynchronous finish flag, and queues each captured 16-bit result.
//
// Handshake note: the FIFO read side is a plain FWFT interface. rd_data_out
// shows the head whenever fifo_empty_out is 0; asserting rd_en_in at a rising
// edge while not empty consumes the head and the next head appears after that
// edge. rd_en_in while empty is ignored. The ADC side uses a start pulse out
// and a finish level in (result_in held stable while the finish flag is high).
module adc_conv_sequencer #(
  parameter int FIFO_DEPTH         = 8,
  parameter int START_PULSE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES     = 4095
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_in,
  input  logic                         continuous_in,
  input  logic                         trigger_in,
  input  logic [15:0]                  period_in,
  output logic                         start_conversion_out,
  input  logic                         conversion_finished_in,
  input  logic [15:0]                  result_in,
  input  logic                         rd_en_in,
  output logic [15:0]                  rd_data_out,
  output logic                         fifo_empty_out,
  output logic                         fifo_full_out,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_out,
  output logic                         busy_out,
  output logic                         overflow_out,
  output logic                         timeout_out,
  input  logic                         clear_flags_in,
  output logic [1:0]                   dbg_state_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (START_PULSE_CYCLES > 1) ? $clog2(START_PULSE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_START       = 2'd1,
    S_WAIT_DONE   = 2'd2,
    S_WAIT_PERIOD = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            r_s1;
  logic            r_s2;
  logic            r_s3;
  logic            w_fin_rise;

  logic [15:0]     r_period_q;
  logic [15:0]     r_period_cnt;
  logic [PW-1:0]   r_pulse_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic            r_start;

  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic            r_overflow;
  logic            r_timeout;

  logic            w_start_entry;
  logic            w_pulse_done;
  logic            w_period_hit;
  logic            w_timeout_hit;
  logic            w_wr_req;
  logic            w_to_set;
  logic            w_wr_do;
  logic            w_rd_do;
  logic            w_empty;
  logic            w_full;
  logic            w_ovf_set;

  // Two-flop resynchroniser for the asynchronous finish flag plus an edge flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= conversion_finished_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_fin_rise = r_s2 & ~r_s3;

  assign w_pulse_done  = (r_pulse_cnt == PW'(START_PULSE_CYCLES - 1));
  // Compare in 17 bits so period_q of 0 or 1 both mean back-to-back.
  assign w_period_hit  = (({1'b0, r_period_cnt} + 17'd1) >= {1'b0, r_period_q});
  assign w_timeout_hit = (r_to_cnt >= TW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and the write/timeout requests raised in WAIT_DONE.
  always_comb begin
    w_next_state = r_state;
    w_wr_req     = 1'b0;
    w_to_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_in && (continuous_in || trigger_in)) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        // A finish edge seen here belongs to the previous conversion.
        if (w_pulse_done) begin
          w_next_state = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (w_fin_rise) begin
          w_wr_req     = 1'b1;
          w_next_state = (continuous_in && enable_in) ? S_WAIT_PERIOD : S_IDLE;
        end else if (w_timeout_hit) begin
          w_to_set     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_PERIOD: begin
        if (!(enable_in && continuous_in)) begin
          w_next_state = S_IDLE;
        end else if (w_period_hit) begin
          w_next_state = S_START;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_start_entry = (w_next_state == S_START) && (r_state != S_START);

  // Start pulse register and the period / pulse / timeout counters, all
  // restarted on every entry into START so they measure from the first
  // START cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start      <= 1'b0;
      r_period_q   <= '0;
      r_period_cnt <= '0;
      r_pulse_cnt  <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_start <= (w_next_state == S_START);
      if (w_start_entry) begin
        r_period_q   <= period_in;
        r_period_cnt <= '0;
        r_pulse_cnt  <= '0;
        r_to_cnt     <= '0;
      end else begin
        if ((r_state != S_IDLE) && (r_period_cnt != 16'hFFFF)) begin
          r_period_cnt <= r_period_cnt + 16'd1;
        end
        if (r_state == S_START) begin
          r_pulse_cnt <= r_pulse_cnt + 1'b1;
        end
        if (((r_state == S_START) || (r_state == S_WAIT_DONE)) && !w_timeout_hit) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

  // FIFO control: a write into a full FIFO only lands if a pop frees a slot
  // on the same edge; a pop of an empty FIFO is dropped.
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_rd_do   = rd_en_in & ~w_empty;
  assign w_wr_do   = w_wr_req & (~w_full | w_rd_do);
  assign w_ovf_set = w_wr_req & w_full & ~w_rd_do;

  // Result storage; result_in is stable while the finish flag is high, so
  // sampling it two cycles after the synchronised edge is safe.
  always_ff @(posedge clk) begin
    if (w_wr_do) begin
      r_mem[r_wr_ptr] <= result_in;
    end
  end

  // Pointers, fill level and sticky flags (set wins over clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_wr_do) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_do) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_do, w_rd_do})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_overflow <= w_ovf_set | (r_overflow & ~clear_flags_in);
      r_timeout  <= w_to_set  | (r_timeout  & ~clear_flags_in);
    end
  end

  assign start_conversion_out = r_start;
  assign rd_data_out          = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
  assign fifo_empty_out       = w_empty;
  assign fifo_full_out        = w_full;
  assign fifo_level_out       = r_level;
  assign busy_out             = (r_state != S_IDLE);
  assign overflow_out         = r_overflow;
  assign timeout_out          = r_timeout;
  assign dbg_state_out        = r_state;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: behavioural ADC model, queue-based reference
// of the result FIFO and sticky flags, directed scenarios plus random phases.
module tb_adc_conv_sequencer;

  localparam int DEPTH = 8;
  localparam int SPC   = 2;
  localparam int TO    = 100;
  localparam int CONV  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_in = 1'b0;
  logic        continuous_in = 1'b0;
  logic        trigger_in = 1'b0;
  logic [15:0] period_in = 16'd0;
  logic        start_conversion_out;
  logic        conversion_finished_in = 1'b0;
  logic [15:0] result_in = 16'd0;
  logic        rd_en_in = 1'b0;
  logic [15:0] rd_data_out;
  logic        fifo_empty_out;
  logic        fifo_full_out;
  logic [3:0]  fifo_level_out;
  logic        busy_out;
  logic        overflow_out;
  logic        timeout_out;
  logic        clear_flags_in = 1'b0;
  logic [1:0]  dbg_state_out;

  adc_conv_sequencer #(
    .FIFO_DEPTH(DEPTH), .START_PULSE_CYCLES(SPC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .continuous_in(continuous_in),
    .trigger_in(trigger_in), .period_in(period_in),
    .start_conversion_out(start_conversion_out),
    .conversion_finished_in(conversion_finished_in), .result_in(result_in),
    .rd_en_in(rd_en_in), .rd_data_out(rd_data_out), .fifo_empty_out(fifo_empty_out),
    .fifo_full_out(fifo_full_out), .fifo_level_out(fifo_level_out),
    .busy_out(busy_out), .overflow_out(overflow_out), .timeout_out(timeout_out),
    .clear_flags_in(clear_flags_in), .dbg_state_out(dbg_state_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          wr_edge_q[$];
  logic [15:0] wr_val_q[$];
  int          to_edge_q[$];
  bit          exp_ovf = 1'b0;
  bit          exp_to = 1'b0;
  int          start_log[$];
  int          fin_log[$];
  logic [15:0] fin_val_log[$];
  bit          adc_hang = 1'b0;
  bit          use_fixed = 1'b0;
  logic [15:0] fixed_val = 16'h0000;
  bit          rand_rd = 1'b0;
  bit          adc_pend = 1'b0;
  int          adc_cnt = 0;
  bit          prev_start = 1'b0;
  int          pulse_w = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: at each edge apply pop, then any finishes due at this edge,
  // then timeout events, then sticky-flag clear.
  task automatic model_edge();
    bit pop_ok;
    bit ovf_set;
    bit to_set;
    int sz;
    logic [15:0] v;
    ovf_set = 1'b0;
    to_set  = 1'b0;
    sz      = exp_q.size();
    pop_ok  = rd_en_in && (sz > 0);
    if (pop_ok) void'(exp_q.pop_front());
    while (wr_edge_q.size() > 0 && wr_edge_q[0] == cyc) begin
      void'(wr_edge_q.pop_front());
      v = wr_val_q.pop_front();
      if (sz < DEPTH || pop_ok) exp_q.push_back(v);
      else ovf_set = 1'b1;
    end
    while (to_edge_q.size() > 0 && to_edge_q[0] == cyc) begin
      void'(to_edge_q.pop_front());
      to_set = 1'b1;
    end
    exp_ovf = ovf_set | (exp_ovf & !clear_flags_in);
    exp_to  = to_set  | (exp_to  & !clear_flags_in);
  endtask

  initial begin : ref_model
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) model_edge();
    end
  end

  // Every-cycle comparison of FIFO view and sticky flags against the model.
  initial begin : cycle_checker
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("level", fifo_level_out, exp_q.size());
        check("empty", fifo_empty_out, exp_q.size() == 0);
        check("full", fifo_full_out, exp_q.size() == DEPTH);
        check("head", rd_data_out, (exp_q.size() > 0) ? exp_q[0] : 16'h0000);
        check("overflow", overflow_out, exp_ovf);
        check("timeout", timeout_out, exp_to);
      end
    end
  end

  // Behavioural ADC: finish rises CONV cycles after the start pulse rises,
  // drops when the next start pulse is seen.
  initial begin : adc_model
    logic [15:0] v;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 1'b0;
        adc_pend   = 1'b0;
        pulse_w    = 0;
      end else begin
        if (start_conversion_out) begin
          pulse_w++;
        end else if (prev_start) begin
          check("pulse_width", pulse_w, SPC);
          pulse_w = 0;
        end
        if (start_conversion_out && !prev_start) begin
          start_log.push_back(cyc);
          conversion_finished_in = 1'b0;
          if (adc_hang) begin
            to_edge_q.push_back(cyc + TO);
          end else begin
            adc_pend = 1'b1;
            adc_cnt  = CONV;
          end
        end else if (adc_pend) begin
          adc_cnt--;
          if (adc_cnt == 0) begin
            v = use_fixed ? fixed_val : 16'($urandom);
            result_in = v;
            conversion_finished_in = 1'b1;
            adc_pend = 1'b0;
            wr_edge_q.push_back(cyc + 3);
            wr_val_q.push_back(v);
            fin_log.push_back(cyc);
            fin_val_log.push_back(v);
          end
        end
        prev_start = start_conversion_out;
      end
    end
  end

  // Random reader, active only when enabled.
  initial begin : rand_reader
    forever begin
      @(negedge clk);
      if (rand_rd) rd_en_in = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_trigger(output int k);
    trigger_in = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    trigger_in = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags_in = 1'b1;
    @(negedge clk);
    clear_flags_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while (busy_out !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, busy_out, 1'b0);
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (start_log.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, start_log.size() >= n, 1'b1);
  endtask

  task automatic wait_fins(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (fin_log.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, fin_log.size() >= n, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (fifo_empty_out !== 1'b1 && t < 2 * DEPTH) begin
      rd_en_in = 1'b1;
      @(negedge clk);
      t++;
    end
    rd_en_in = 1'b0;
  endtask

  task automatic clear_logs();
    start_log.delete();
    fin_log.delete();
    fin_val_log.delete();
  endtask

  task automatic run_periodic(input string tag, input int p, input int n);
    int want;
    clear_logs();
    period_in = 16'(p);
    continuous_in = 1'b1;
    wait_starts({tag, "_starts"}, n, 100 * n + 200);
    continuous_in = 1'b0;
    wait_idle({tag, "_idle"}, 200);
    want = (p > CONV + 4) ? p : CONV + 4;
    if (start_log.size() >= n) begin
      for (int i = 0; i + 1 < n; i++) begin
        check({tag, "_spacing"}, start_log[i + 1] - start_log[i], want);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int k;
    int e;
    logic [15:0] order[$];

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_start", start_conversion_out, 1'b0);
    check("rst_rd_data", rd_data_out, 16'h0000);
    check("rst_empty", fifo_empty_out, 1'b1);
    check("rst_level", fifo_level_out, 4'd0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_state", dbg_state_out, 2'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single shot with a known value.
    use_fixed = 1'b1;
    fixed_val = 16'hA5C3;
    enable_in = 1'b1;
    clear_logs();
    pulse_trigger(k);
    check("ss_busy", busy_out, 1'b1);
    wait_fins("ss_fin", 1, 200);
    if (fin_log.size() >= 1) begin
      check("ss_start_edge", start_log[0], k);
      e = fin_log[0];
      wait_until_cyc(e + 2);
      check("ss_not_yet", fifo_empty_out, 1'b1);
      wait_until_cyc(e + 3);
      check("ss_data", rd_data_out, 16'hA5C3);
      check("ss_level", fifo_level_out, 4'd1);
    end
    wait_idle("ss_idle", 50);
    check("ss_one_start", start_log.size(), 1);
    drain();
    use_fixed = 1'b0;

    // Continuous: period dominates, then conversion time dominates.
    rand_rd = 1'b1;
    run_periodic("cont50", 50, 5);
    run_periodic("cont10", 10, 5);
    rand_rd = 1'b0;
    @(negedge clk);
    rd_en_in = 1'b0;
    drain();
    pulse_clear();

    // Overflow: ten back-to-back conversions, no reads.
    clear_logs();
    period_in = 16'd0;
    continuous_in = 1'b1;
    wait_fins("ovf_fins", 10, 600);
    continuous_in = 1'b0;
    wait_idle("ovf_idle", 100);
    check("ovf_level", fifo_level_out, 4'd8);
    check("ovf_full", fifo_full_out, 1'b1);
    check("ovf_flag", overflow_out, 1'b1);
    check("ovf_count", fin_log.size(), 10);
    if (fin_val_log.size() >= 8) check("ovf_head", rd_data_out, fin_val_log[0]);
    // Pop and write on the same edge while full.
    pulse_trigger(k);
    wait_fins("ovf_pw_fin", 11, 200);
    if (fin_log.size() >= 11) begin
      e = fin_log[10];
      wait_until_cyc(e + 2);
      rd_en_in = 1'b1;
      @(negedge clk);
      rd_en_in = 1'b0;
      check("pw_level", fifo_level_out, 4'd8);
      check("pw_full", fifo_full_out, 1'b1);
      order.delete();
      for (int i = 1; i < 8; i++) order.push_back(fin_val_log[i]);
      order.push_back(fin_val_log[10]);
      for (int i = 0; i < 8; i++) begin
        check("pw_order", rd_data_out, order[i]);
        rd_en_in = 1'b1;
        @(negedge clk);
        rd_en_in = 1'b0;
      end
      check("pw_drained", fifo_empty_out, 1'b1);
    end
    wait_idle("pw_idle", 50);
    pulse_clear();
    check("ovf_cleared", overflow_out, 1'b0);

    // Timeout: the ADC never finishes.
    adc_hang = 1'b1;
    clear_logs();
    pulse_trigger(k);
    wait_until_cyc(k + TO - 1);
    check("to_early", timeout_out, 1'b0);
    check("to_busy_early", busy_out, 1'b1);
    @(negedge clk);
    check("to_set", timeout_out, 1'b1);
    check("to_state", dbg_state_out, 2'd0);
    check("to_nowrite", fifo_level_out, 4'd0);
    adc_hang = 1'b0;
    pulse_clear();
    check("to_cleared", timeout_out, 1'b0);

    // Enable drop in WAIT_DONE during continuous mode.
    clear_logs();
    period_in = 16'd50;
    continuous_in = 1'b1;
    wait_starts("ed_start", 1, 20);
    if (start_log.size() >= 1) wait_until_cyc(start_log[0] + 5);
    enable_in = 1'b0;
    wait_idle("ed_idle", 100);
    repeat (60) @(negedge clk);
    check("ed_starts", start_log.size(), 1);
    check("ed_fins", fin_log.size(), 1);
    check("ed_level", fifo_level_out, 4'd1);
    continuous_in = 1'b0;
    enable_in = 1'b1;

    // Asynchronous reset in WAIT_DONE with data queued.
    clear_logs();
    pulse_trigger(k);
    wait_until_cyc(k + 6);
    #2 rst = 1'b1;
    #1;
    check("arst_start", start_conversion_out, 1'b0);
    check("arst_rd_data", rd_data_out, 16'h0000);
    check("arst_empty", fifo_empty_out, 1'b1);
    check("arst_full", fifo_full_out, 1'b0);
    check("arst_level", fifo_level_out, 4'd0);
    check("arst_busy", busy_out, 1'b0);
    check("arst_ovf", overflow_out, 1'b0);
    check("arst_to", timeout_out, 1'b0);
    check("arst_state", dbg_state_out, 2'd0);
    exp_q.delete();
    wr_edge_q.delete();
    wr_val_q.delete();
    to_edge_q.delete();
    exp_ovf = 1'b0;
    exp_to = 1'b0;
    conversion_finished_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random periods with a random reader.
    rand_rd = 1'b1;
    for (int it = 0; it < 4; it++) begin
      run_periodic("rand", $urandom_range(0, 60), 4);
    end
    rand_rd = 1'b0;
    @(negedge clk);
    rd_en_in = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
